// File: rtl/door_input_conditioner_if.sv
// rtl/door_input_conditioner_if.sv - raw door inputs and conditioned controller-side signals
interface door_input_conditioner_if;
  logic btn_raw;
  logic up_sw_raw;
  logic dn_sw_raw;
  logic activate;
  logic Up_max;
  logic Dn_max;
  logic sensor_fault;

  modport master (
    output btn_raw, up_sw_raw, dn_sw_raw,
    input  activate, Up_max, Dn_max, sensor_fault
  );

  modport slave (
    input  btn_raw, up_sw_raw, dn_sw_raw,
    output activate, Up_max, Dn_max, sensor_fault
  );
endinterface

// File: rtl/door_input_conditioner.sv
// rtl/door_input_conditioner.sv - sync/debounce of button and limits, one-shot activate, fault flag
// Optional press lockout after each pulse when DOOR_INPUT_LOCKOUT_EN is defined.
module door_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input logic                    clock,
  input logic                    reset,
  door_input_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {BTN_RELEASED, BTN_PRESSED} btn_state_t;

  // bit 0 = button, bit 1 = fully-open limit, bit 2 = fully-closed limit
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [CW-1:0] cnt [3];
  btn_state_t    state_q;
  btn_state_t    state_d;
  logic          act_d;
  logic          act_q;
  logic          fault_q;
  logic          limits_both;
  logic          locked;

  assign raw = {io.dn_sw_raw, io.up_sw_raw, io.btn_raw};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A new level must hold for DEBOUNCE_CYCLES consecutive samples; any return clears the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign limits_both = deb[1] & deb[2];

`ifdef DOOR_INPUT_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q <= '0;
    end else if (act_d) begin
      lock_q <= LW'(LOCKOUT_CYCLES);
    end else if (lock_q != '0) begin
      lock_q <= lock_q - LW'(1);
    end
  end

  assign locked = (lock_q != '0);
`else
  // Zero is outside the legal range; a misconfigured instance stays silent rather than pulsing.
  assign locked = (LOCKOUT_CYCLES == 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BTN_RELEASED;
      act_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      fault_q <= limits_both;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = 1'b0;
    case (state_q)
      BTN_RELEASED: begin
        if (deb[0]) begin
          state_d = BTN_PRESSED;
          act_d   = !limits_both && !locked;
        end
      end
      BTN_PRESSED: begin
        if (!deb[0]) state_d = BTN_RELEASED;
      end
      default: state_d = BTN_RELEASED;
    endcase
  end

  assign io.activate     = act_q;
  assign io.Up_max       = deb[1];
  assign io.Dn_max       = deb[2];
  assign io.sensor_fault = fault_q;
endmodule

// File: doc/door_input_conditioner.md
Name: door_input_conditioner

Overview:
- Upstream front end for the garage door controller FSM.
- Takes the raw asynchronous wall/remote push-button and the two mechanical limit switches. Synchronises and debounces all three.
- Turns each button press into exactly one single-cycle `activate` pulse.
- Drives the controller's `activate`, `Up_max` and `Dn_max` inputs. Flags a sensor fault when both limits read closed together.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clock cycles a synchronised input must hold a new level before the debounced level changes; legal range 1..65535.
- LOCKOUT_CYCLES, 16, cycles after an `activate` pulse during which new presses are ignored (used only with LOCKOUT_EN); legal range 1..65535.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- btn_raw  input  1  raw push-button, active-high, asynchronous, bouncy
- up_sw_raw  input  1  raw fully-open limit switch, active-high, asynchronous, bouncy
- dn_sw_raw  input  1  raw fully-closed limit switch, active-high, asynchronous, bouncy
- activate  output  1  single-cycle press pulse to the door controller
- Up_max  output  1  debounced fully-open level
- Dn_max  output  1  debounced fully-closed level
- sensor_fault  output  1  high while both debounced limits are 1

Behaviour:
- Reset (reset=0, asynchronous): every synchroniser flop, debounced level and counter clears to 0. The button FSM goes to BTN_RELEASED. activate, Up_max, Dn_max and sensor_fault are all 0.
- Synchroniser:
  - Each raw input passes through 2 flops.
  - A raw level sampled at edge k appears at the synchroniser output after edge k+1.
- Debounce, one instance per input:
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - When the synchronised value equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Any glitch back to the current level before that clears the counter; there is no partial credit.
  - Latency: if a raw input is steady at a new level from edge k, the debounced level changes at edge k+DEBOUNCE_CYCLES+1.
- Up_max and Dn_max are the registered debounced limit levels; they add no extra latency.
- sensor_fault = debounced up AND debounced down, registered. It rises or falls one edge after the second limit changes.
- Button FSM, 2 states:
  - BTN_RELEASED: if debounced button = 1 and the debounced limits are not both 1, pulse activate and go to BTN_PRESSED. If debounced button = 1 while both limits are 1, go to BTN_PRESSED without pulsing (the press is swallowed).
  - BTN_PRESSED: stay until debounced button = 0, then go to BTN_RELEASED. No pulse.
  - activate is registered. It is high for exactly one cycle, starting one edge after the debounced button rises.
  - A held button never repeats.
- Simultaneous events: the limits are evaluated in the same cycle as the button. A fault present in that cycle suppresses the pulse.
- Reset mid-operation: all pulses and counters abort immediately. A button held through reset deassertion is treated as a new press and produces one pulse after the full debounce latency.
- Width rules: counters saturate; they never wrap.

Optional Feature:
- Macro: DOOR_INPUT_LOCKOUT_EN.
- Defined:
  - A lockout counter loads LOCKOUT_CYCLES on each activate pulse and decrements to 0.
  - While it is nonzero, a BTN_RELEASED to pressed transition moves to BTN_PRESSED without pulsing.
  - Reset clears the counter.
- Undefined: no lockout counter exists; every qualified press pulses.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: btn_raw 0→1 sampled at edge 10 and held 20 cycles → debounced button rises at edge 15; activate=1 for exactly the cycle after edge 16; no second pulse while held.
- Bounce: btn_raw toggles 1,0,1,0 (1 cycle each) from edge 10, then steady 1 from edge 14 → exactly one activate pulse, after edge 20; no pulse from the bounces.
- Limits: up_sw_raw steady 1 from edge 5 → Up_max=1 after edge 10. A 3-cycle glitch on dn_sw_raw leaves Dn_max=0.
- Fault: both limits steady 1, then a clean press → sensor_fault=1, activate stays 0. Release, clear dn_sw_raw, press again → one pulse.
- Reset mid-debounce: btn_raw=1 for 3 cycles, then reset=0 asynchronously mid-cycle → all outputs 0 immediately. Release reset with btn_raw still 1 → one pulse after DEBOUNCE_CYCLES+2 edges.
- Lockout (DOOR_INPUT_LOCKOUT_EN, LOCKOUT_CYCLES=16): two clean presses 10 cycles apart → one pulse only. Presses 30 cycles apart → two pulses.
